// File: rtl/aes_block_packer_if.sv
// AXI-Stream style handshake bundle used on both sides of aes_block_packer.
//   tdata  : payload, DATA_W bits
//   tvalid : source has data
//   tready : sink accepts data (transfer on tvalid && tready)
//   tlast  : final beat of a message
// master drives payload/valid/last, slave drives ready.
interface aes_block_packer_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/aes_block_packer.sv
// aes_block_packer: collects an 8-bit byte stream into 128-bit plaintext blocks for the AES core.
// Byte k of a block lands in tdata[127-8k -: 8]. Short messages are padded and flushed on input
// tlast or after TIMEOUT_CYCLES idle cycles with a partial block (0 disables the timeout).
//
// Optional feature macro: AES_PACK_PKCS7_EN
//   defined   : PKCS#7 padding; a message ending on a block boundary is followed by a full
//               block of 16 x 8'h10 (tlast=1) and the data block carries tlast=0.
//   undefined : pad bytes are 8'h00, no extra block.
//
// Ports
//   Clk      : clock, posedge
//   Rst      : synchronous active-high reset
//   En       : block enable; low behaves exactly like Rst
//   s_axis   : 8-bit byte input (slave)
//   m_axis   : 128-bit block output (master)
//   BlockCnt : blocks emitted since reset, wraps modulo 2^CNT_W
module aes_block_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  aes_block_packer_if.slave  s_axis,
  aes_block_packer_if.master m_axis,
  output logic [CNT_W-1:0]   BlockCnt
);

  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

`ifdef AES_PACK_PKCS7_EN
  typedef enum logic [1:0] {StFill, StOutput, StPadBlk} state_e;
`else
  typedef enum logic [1:0] {StFill, StOutput} state_e;
`endif

  state_e             state_q, state_d;
  logic [127:0]       buf_q, buf_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic               tlast_q, tlast_d;
  logic [CNT_W-1:0]   blk_q, blk_d;
`ifdef AES_PACK_PKCS7_EN
  logic               pad_pend_q, pad_pend_d;  // boundary-aligned message owes a PADBLK
`endif

  logic       active;
  logic       accept;
  logic [4:0] cnt_inc;
  logic       full_blk;
  logic       tlast_flush;
  logic       idle_flush;
  logic [4:0] pad_from;
  logic [7:0] pad_byte;

  assign active      = En && !Rst;
  assign accept      = s_axis.tvalid && s_axis.tready;
  assign cnt_inc     = cnt_q + 5'd1;
  assign full_blk    = accept && (cnt_inc == 5'd16);
  assign tlast_flush = accept && s_axis.tlast && (cnt_inc != 5'd16);
  // An accept in the same cycle always wins over the timeout.
  assign idle_flush  = TimeoutEn && !accept && (state_q == StFill) && (cnt_q != 5'd0) &&
                       (idle_q == IdleLast);
  // First byte position to pad: after the byte just accepted, or after the current fill level.
  assign pad_from    = accept ? cnt_inc : cnt_q;
`ifdef AES_PACK_PKCS7_EN
  assign pad_byte    = {3'b000, 5'd16 - pad_from};
`else
  assign pad_byte    = 8'h00;
`endif

  // State register plus datapath registers; En low clears everything like Rst.
  always_ff @(posedge Clk) begin
    if (!active) begin
      state_q    <= StFill;
      buf_q      <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      tlast_q    <= 1'b0;
      blk_q      <= '0;
`ifdef AES_PACK_PKCS7_EN
      pad_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      tlast_q    <= tlast_d;
      blk_q      <= blk_d;
`ifdef AES_PACK_PKCS7_EN
      pad_pend_q <= pad_pend_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: begin
        if (full_blk || tlast_flush || idle_flush) state_d = StOutput;
      end
      StOutput: begin
        if (m_axis.tready) begin
`ifdef AES_PACK_PKCS7_EN
          state_d = pad_pend_q ? StPadBlk : StFill;
`else
          state_d = StFill;
`endif
        end
      end
`ifdef AES_PACK_PKCS7_EN
      StPadBlk: state_d = StOutput;
`endif
      default: state_d = StFill;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    tlast_d = tlast_q;
    blk_d   = blk_q;
`ifdef AES_PACK_PKCS7_EN
    pad_pend_d = pad_pend_q;
`endif
    unique case (state_q)
      StFill: begin
        if (accept) begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) == cnt_q) buf_d[8*(15-i) +: 8] = s_axis.tdata;
          end
          cnt_d  = cnt_inc;
          idle_d = '0;
        end else if (TimeoutEn && (cnt_q != 5'd0) && !idle_flush) begin
          idle_d = idle_q + 1'b1;
        end
        if (full_blk) begin
`ifdef AES_PACK_PKCS7_EN
          tlast_d    = 1'b0;
          pad_pend_d = s_axis.tlast;
`else
          tlast_d    = s_axis.tlast;
`endif
        end
        if (tlast_flush || idle_flush) begin
          tlast_d = 1'b1;
          for (int i = 0; i < 16; i++) begin
            if (5'(i) >= pad_from) buf_d[8*(15-i) +: 8] = pad_byte;
          end
        end
      end
      StOutput: begin
        if (m_axis.tready) begin
          blk_d  = blk_q + 1'b1;
          cnt_d  = '0;
          idle_d = '0;
          buf_d  = '0;
        end
      end
`ifdef AES_PACK_PKCS7_EN
      StPadBlk: begin
        buf_d      = {16{8'h10}};
        tlast_d    = 1'b1;
        pad_pend_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // Outputs; all forced to zero while held in reset or disabled.
  always_comb begin
    s_axis.tready = active && (state_q == StFill);
    m_axis.tvalid = active && (state_q == StOutput);
    m_axis.tdata  = active ? buf_q : '0;
    m_axis.tlast  = active && (state_q == StOutput) && tlast_q;
    BlockCnt      = active ? blk_q : '0;
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed scenarios plus randomized messages
// with random downstream backpressure, checked against a message-level padding model.
`timescale 1ns/1ps
module tb_aes_block_packer;

  localparam int unsigned To = 8;
`ifdef AES_PACK_PKCS7_EN
  localparam bit Pkcs = 1'b1;
`else
  localparam bit Pkcs = 1'b0;
`endif

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } blk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] blk_cnt;
  logic        man_rdy;
  logic        rnd_rdy = 1'b0;
  bit          bp_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  blk_t        got_q[$];
  blk_t        exp_q[$];

  aes_block_packer_if #(.DATA_W(8))   s_if ();
  aes_block_packer_if #(.DATA_W(128)) m_if ();

  aes_block_packer #(
    .TIMEOUT_CYCLES(To),
    .CNT_W         (16)
  ) dut (
    .Clk     (clk),
    .Rst     (rst),
    .En      (en),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .BlockCnt(blk_cnt)
  );

  always #5 clk = ~clk;

  assign m_if.tready = bp_en ? rnd_rdy : man_rdy;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Collect every completed output transfer.
  always @(negedge clk) begin
    if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tlast, m_if.tdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference: one padded block from msg[pos +: r], r <= 16.
  function automatic logic [127:0] pad_blk(input logic [7:0] msg[$], input int pos, input int r);
    logic [127:0] d;
    logic [7:0]   padv;
    padv = Pkcs ? 8'(16 - r) : 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (k < r) d[127-8*k -: 8] = msg[pos+k];
      else       d[127-8*k -: 8] = padv;
    end
    return d;
  endfunction

  // Reference: the block sequence a whole message ending in tlast must produce.
  function automatic void model_msg(input logic [7:0] msg[$]);
    int n;
    int pos;
    int r;
    n = msg.size();
    pos = 0;
    while (pos < n) begin
      r = (n - pos >= 16) ? 16 : n - pos;
      if (pos + r == n) begin
        if (r == 16 && Pkcs) begin
          exp_q.push_back({1'b0, pad_blk(msg, pos, r)});
          exp_q.push_back({1'b1, {16{8'h10}}});
        end else begin
          exp_q.push_back({1'b1, pad_blk(msg, pos, r)});
        end
      end else begin
        exp_q.push_back({1'b0, pad_blk(msg, pos, r)});
      end
      pos += r;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit last);
    int guard;
    guard = 0;
    s_if.tdata  = b;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.tready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_if.tready) begin
      checks++;
      errors++;
      $display("FAIL send_stall got tready=0 required 1 within 3000 cycles");
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
    man_rdy = 1'b0;
    step(2);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    man_rdy = 1'b1;
    step(1);
    man_rdy = 1'b0;
  endtask

  task automatic cmp_queues(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got %0d blocks required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_blk%0d got last=%0b data=%h required last=%0b data=%h", name, i,
                 got_q[i].last, got_q[i].data, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    man_rdy = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h55;
    step(3);
    checks += 5;
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b required 0", s_if.tready); end
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b required 0", m_if.tvalid); end
    if (m_if.tdata !== 128'h0) begin errors++; $display("FAIL rst_tdata got %h required 0", m_if.tdata); end
    if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b required 0", m_if.tlast); end
    if (blk_cnt !== 16'h0) begin errors++; $display("FAIL rst_blkcnt got %0d required 0", blk_cnt); end
    s_if.tvalid = 1'b0;
    man_rdy = 1'b0;
    rst = 1'b0;
    step(1);
    checks++;
    if (s_if.tready !== 1'b1) begin errors++; $display("FAIL fill_tready got %b required 1", s_if.tready); end
  endtask

  task automatic test_full_block();
    logic [127:0] exp;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp[127-8*k -: 8] = 8'(k);
      send_byte(8'(k), 1'b0);
    end
    checks += 5;
    if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL full_latency got tvalid=%b required 1", m_if.tvalid); end
    if (m_if.tdata !== exp) begin errors++; $display("FAIL full_data got %h required %h", m_if.tdata, exp); end
    if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL full_tlast got %b required 0", m_if.tlast); end
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b required 0", s_if.tready); end
    if (blk_cnt !== 16'd0) begin errors++; $display("FAIL full_cnt_pre got %0d required 0", blk_cnt); end
    drain();
    checks += 2;
    if (blk_cnt !== 16'd1) begin errors++; $display("FAIL full_cnt got %0d required 1", blk_cnt); end
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL full_release got tvalid=%b required 0", m_if.tvalid); end
  endtask

  task automatic test_short_msg();
    logic [7:0]   msg[$];
    logic [127:0] exp;
    do_reset();
    msg = '{8'hAA, 8'hBB, 8'hCC};
    exp = pad_blk(msg, 0, 3);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    checks += 3;
    if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL short_tvalid got %b required 1", m_if.tvalid); end
    if (m_if.tdata !== exp) begin errors++; $display("FAIL short_data got %h required %h", m_if.tdata, exp); end
    if (m_if.tlast !== 1'b1) begin errors++; $display("FAIL short_tlast got %b required 1", m_if.tlast); end
    drain();
  endtask

  task automatic test_boundary_tlast();
    logic [7:0] msg[$];
    do_reset();
    for (int k = 0; k < 16; k++) msg.push_back(8'($urandom));
    model_msg(msg);
    man_rdy = 1'b1;
    for (int k = 0; k < 16; k++) send_byte(msg[k], k == 15);
    step(20);
    man_rdy = 1'b0;
    cmp_queues("boundary");
    checks++;
    if (blk_cnt !== 16'(exp_q.size())) begin
      errors++;
      $display("FAIL boundary_cnt got %0d required %0d", blk_cnt, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    logic [7:0]   msg[$];
    logic [127:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      msg.push_back(8'($urandom));
      send_byte(msg[k], 1'b0);
    end
    step(To - 1);
    checks++;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL to_early got tvalid=%b required 0", m_if.tvalid); end
    step(1);
    exp = pad_blk(msg, 0, 5);
    checks += 3;
    if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL to_flush got tvalid=%b required 1", m_if.tvalid); end
    if (m_if.tdata !== exp) begin errors++; $display("FAIL to_data got %h required %h", m_if.tdata, exp); end
    if (m_if.tlast !== 1'b1) begin errors++; $display("FAIL to_tlast got %b required 1", m_if.tlast); end
    drain();
    // A byte arriving on the final idle cycle restarts the idle count.
    msg.delete();
    for (int k = 0; k < 5; k++) begin
      msg.push_back(8'($urandom));
      send_byte(msg[k], 1'b0);
    end
    step(To - 1);
    msg.push_back(8'($urandom));
    send_byte(msg[5], 1'b0);
    checks++;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL to_race got tvalid=%b required 0", m_if.tvalid); end
    step(To - 1);
    checks++;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL to_restart got tvalid=%b required 0", m_if.tvalid); end
    step(1);
    exp = pad_blk(msg, 0, 6);
    checks += 2;
    if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL to_flush2 got tvalid=%b required 1", m_if.tvalid); end
    if (m_if.tdata !== exp) begin errors++; $display("FAIL to_data2 got %h required %h", m_if.tdata, exp); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] msg[$];
    logic [7:0] tail[$];
    int         bad;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      msg.push_back(8'($urandom));
      send_byte(msg[k], 1'b0);
    end
    exp_q.push_back({1'b0, pad_blk(msg, 0, 16)});
    tail.push_back(8'h5A);
    exp_q.push_back({1'b1, pad_blk(tail, 0, 1)});
    s_if.tdata  = 8'h5A;
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (m_if.tdata !== exp_q[0].data || s_if.tready !== 1'b0 || m_if.tvalid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles required 0", bad);
    end
    man_rdy = 1'b1;
    send_byte(8'h5A, 1'b1);
    step(2);
    man_rdy = 1'b0;
    cmp_queues("bp");
  endtask

  task automatic test_reset_mid(input bit use_en);
    logic [7:0]   msg[$];
    logic [127:0] exp;
    do_reset();
    for (int k = 0; k < 16; k++) send_byte(8'($urandom), 1'b0);
    drain();
    for (int k = 0; k < 7; k++) send_byte(8'($urandom), 1'b0);
    if (use_en) en = 1'b0;
    else        rst = 1'b1;
    step(1);
    checks += 4;
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL mid%0d_tready got %b required 0", use_en, s_if.tready); end
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid%0d_tvalid got %b required 0", use_en, m_if.tvalid); end
    if (m_if.tdata !== 128'h0) begin errors++; $display("FAIL mid%0d_tdata got %h required 0", use_en, m_if.tdata); end
    if (blk_cnt !== 16'd0) begin errors++; $display("FAIL mid%0d_cnt got %0d required 0", use_en, blk_cnt); end
    en  = 1'b1;
    rst = 1'b0;
    step(1);
    checks++;
    if (blk_cnt !== 16'd0) begin errors++; $display("FAIL mid%0d_cnt_after got %0d required 0", use_en, blk_cnt); end
    for (int k = 0; k < 16; k++) begin
      msg.push_back(8'($urandom));
      send_byte(msg[k], 1'b0);
    end
    exp = pad_blk(msg, 0, 16);
    checks += 2;
    if (m_if.tdata !== exp) begin errors++; $display("FAIL mid%0d_data got %h required %h", use_en, m_if.tdata, exp); end
    if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL mid%0d_tlast got %b required 0", use_en, m_if.tlast); end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] msg[$];
    int         len;
    int         guard;
    do_reset();
    bp_en = 1'b1;
    for (int m = 0; m < 12; m++) begin
      msg.delete();
      len = $urandom_range(1, 40);
      if (m == 0) len = 32;
      for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
      model_msg(msg);
      for (int k = 0; k < len; k++) begin
        step($urandom_range(0, 2));
        send_byte(msg[k], k == len - 1);
      end
    end
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 2000) begin
      step(1);
      guard++;
    end
    bp_en = 1'b0;
    step(2);
    cmp_queues("rand");
    checks++;
    if (blk_cnt !== 16'(exp_q.size())) begin
      errors++;
      $display("FAIL rand_cnt got %0d required %0d", blk_cnt, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    man_rdy = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
    test_reset();
    test_full_block();
    test_short_msg();
    test_boundary_tlast();
    test_timeout();
    test_backpressure();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
